// File: rtl/mem_stage_pkg.sv
// Shared core types: memory/ALU opcodes, the inter-stage pipeline bus and
// the memory-stage state encoding.
package core;
  localparam int ADDR_WIDTH = 12;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
  } MEM_OP_t;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL
  } ALU_OP_t;

  typedef struct packed {
    logic [31:0] pc;
    ALU_OP_t     alu_op;
    MEM_OP_t     mem_op;
    logic [4:0]  rd;
    logic [31:0] rs2_data;
    logic [31:0] rd_res;
  } pipeline_bus_t;

  typedef enum logic [1:0] {MS_IDLE, MS_ACCESS, MS_HOLD} mem_state_t;

  function automatic logic is_store(MEM_OP_t op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction
endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the memory stage and the memory.
interface mem_stage_if #(parameter int ADDR_W = core::ADDR_WIDTH);
  logic              dmem_req_o;
  logic              dmem_we_o;
  logic [ADDR_W-1:0] dmem_addr_o;
  logic [31:0]       dmem_wdata_o;
  logic [3:0]        dmem_be_o;
  logic              dmem_ack_i;
  logic [31:0]       dmem_rdata_i;

  modport master (output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
                  input  dmem_ack_i, dmem_rdata_i);
  modport slave  (input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
                  output dmem_ack_i, dmem_rdata_i);
endinterface

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/half out of a load word and sign/zero extends it.
module load_align
  import core::*;
(
  input  MEM_OP_t     mem_op,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  output logic [31:0] res
);
  logic [31:0] sh;
  assign sh = rdata >> {off, 3'b000};

  always_comb begin
    res = rdata;
    case (mem_op)
      MEM_LB:  res = {{24{sh[7]}}, sh[7:0]};
      MEM_LBU: res = {24'b0, sh[7:0]};
      MEM_LH:  res = {{16{sh[15]}}, sh[15:0]};
      MEM_LHU: res = {16'b0, sh[15:0]};
      default: res = rdata;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues one load/store at a time to data memory and
// hands the completed instruction to writeback.
module mem_stage
  import core::*;
#(
  parameter int ADDR_W = ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid_i,
  input  pipeline_bus_t ex_bus_i,
  output logic          ex_ready_o,
  output logic          wb_valid_o,
  output pipeline_bus_t wb_bus_o,
  input  logic          wb_ready_i,
  mem_stage_if.master   dmem,
  output logic          misalign_o
);
  mem_state_t        state;
  pipeline_bus_t     bus_q;
  logic              req_q, we_q, mis_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, wdata_n, ld_res;
  logic [3:0]        be_q, be_n;
  logic [1:0]        off;
  logic              mis, is_ls;

  assign off   = ex_bus_i.rd_res[1:0];
  assign is_ls = ex_bus_i.mem_op != MEM_NOP;
  assign mis   = (((ex_bus_i.mem_op == MEM_LH) || (ex_bus_i.mem_op == MEM_LHU) ||
                   (ex_bus_i.mem_op == MEM_SH)) && off[0]) ||
                 (((ex_bus_i.mem_op == MEM_LW) || (ex_bus_i.mem_op == MEM_SW)) && (off != 2'b00));

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = '0;
    case (ex_bus_i.mem_op)
      MEM_LB, MEM_LBU, MEM_SB: be_n = 4'b0001 << off;
      MEM_LH, MEM_LHU, MEM_SH: be_n = 4'b0011 << off;
      default:                 be_n = 4'b1111;
    endcase
    case (ex_bus_i.mem_op)
      MEM_SB:  wdata_n = {4{ex_bus_i.rs2_data[7:0]}};
      MEM_SH:  wdata_n = {2{ex_bus_i.rs2_data[15:0]}};
      MEM_SW:  wdata_n = ex_bus_i.rs2_data;
      default: wdata_n = '0;
    endcase
  end

  load_align u_load_align (
    .mem_op (bus_q.mem_op),
    .off    (bus_q.rd_res[1:0]),
    .rdata  (dmem.dmem_rdata_i),
    .res    (ld_res)
  );

  // Request fields stay frozen for the whole ACCESS state; acks elsewhere are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= MS_IDLE;
      bus_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      mis_q   <= 1'b0;
    end else begin
      mis_q <= 1'b0;
      case (state)
        MS_IDLE: if (ex_valid_i) begin
          bus_q <= ex_bus_i;
          if (is_ls && !mis) begin
            state   <= MS_ACCESS;
            req_q   <= 1'b1;
            we_q    <= is_store(ex_bus_i.mem_op);
            addr_q  <= ex_bus_i.rd_res[ADDR_W+1:2];
            wdata_q <= wdata_n;
            be_q    <= be_n;
          end else begin
            state <= MS_HOLD;
            if (mis) begin
              bus_q.rd     <= '0;
              bus_q.mem_op <= MEM_NOP;
              mis_q        <= 1'b1;
            end
          end
        end
        MS_ACCESS: if (dmem.dmem_ack_i) begin
          state   <= MS_HOLD;
          req_q   <= 1'b0;
          we_q    <= 1'b0;
          addr_q  <= '0;
          wdata_q <= '0;
          be_q    <= '0;
          if (!we_q) bus_q.rd_res <= ld_res;
        end
        MS_HOLD: if (wb_ready_i) state <= MS_IDLE;
        default: state <= MS_IDLE;
      endcase
    end
  end

  assign ex_ready_o        = (state == MS_IDLE) && !rst;
  assign wb_valid_o        = (state == MS_HOLD);
  assign wb_bus_o          = bus_q;
  assign misalign_o        = mis_q;
  assign dmem.dmem_req_o   = req_q;
  assign dmem.dmem_we_o    = we_q;
  assign dmem.dmem_addr_o  = addr_q;
  assign dmem.dmem_wdata_o = wdata_q;
  assign dmem.dmem_be_o    = be_q;
endmodule
